pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_ctrl_if.sv | 31 +++
 rtl/pipeline_ctrl_perf_cnt.sv | 16 +
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and stall/flush encodings for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DIV   = 2'd1,
    ST_MEMW  = 2'd2,
    ST_REDIR = 2'd3
  } ctrl_state_e;

  // Bit positions in the stall/flush vectors, youngest register first.
  localparam int IFID  = 3;
  localparam int IDEX  = 2;
  localparam int EXMEM = 1;
  localparam int MEMWB = 0;

  localparam logic [3:0] STALL_NONE  = 4'b0000;
  localparam logic [3:0] STALL_LDUSE = 4'(1 << IFID);
  localparam logic [3:0] STALL_MULTI = 4'((1 << IFID) | (1 << IDEX) | (1 << EXMEM));

  localparam logic [3:0] FLUSH_NONE  = 4'b0000;
  localparam logic [3:0] FLUSH_ALL   = 4'b1111;
  localparam logic [3:0] FLUSH_BR    = 4'((1 << IFID) | (1 << IDEX));
  localparam logic [3:0] FLUSH_LDUSE = 4'(1 << IDEX);
  localparam logic [3:0] FLUSH_WB    = 4'(1 << MEMWB);
  localparam logic [3:0] FLUSH_REDIR = 4'(1 << IFID);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Event inputs and stall/flush/redirect outputs between the pipeline and its sequencer.
interface pipeline_ctrl_if #(
  parameter int PC_W = 32
);
  logic            ld_use_stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            exc_req;
  logic [PC_W-1:0] exc_vec;
  logic            div_start;
  logic            div_done;
  logic            dmem_req;
  logic            dmem_ack;
  logic            if_ready;
  logic [3:0]      stall;
  logic [3:0]      flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output ld_use_stall, br_taken, br_target, exc_req, exc_vec,
           div_start, div_done, dmem_req, dmem_ack, if_ready,
    input  stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  ld_use_stall, br_taken, br_target, exc_req, exc_vec,
           div_start, div_done, dmem_req, dmem_ack, if_ready,
    output stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipeline_ctrl_perf_cnt.sv
// Free-running event counter that wraps at 2^CNT_W.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges hazards, multi-cycle events and redirects for the 5-stage pipe.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal issue; single-cycle hazards and redirects resolved here
// ST_DIV   | divider busy, front of pipe held, bubble into MEM/WB
// ST_MEMW  | data memory outstanding; exceptions deferred until ack
// ST_REDIR | redirect target buffered until fetch unit accepts it
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.slave    bus,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_state_e     st_q, st_d;
  logic [PC_W-1:0] buf_q, buf_d, pvec_q, pvec_d, req_tgt, rpc;
  logic            pend_q, pend_d, req, rv, redir_evt;
  logic [3:0]      stall_v, flush_v, req_flush;

  always_comb begin
    stall_v   = STALL_NONE;
    flush_v   = FLUSH_NONE;
    rv        = 1'b0;
    rpc       = '0;
    st_d      = st_q;
    buf_d     = buf_q;
    pend_d    = pend_q;
    pvec_d    = pvec_q;
    req       = 1'b0;
    req_tgt   = '0;
    req_flush = FLUSH_NONE;
    redir_evt = 1'b0;
    if (rst) begin
      flush_v = FLUSH_ALL;
    end else begin
      case (st_q)
        ST_RUN: begin
          // A deferred exception is older than anything arriving now.
          if (pend_q || bus.exc_req) begin
            req       = 1'b1;
            req_tgt   = pend_q ? pvec_q : bus.exc_vec;
            req_flush = FLUSH_ALL;
            pend_d    = 1'b0;
          end else if (bus.dmem_req && !bus.dmem_ack) begin
            stall_v = STALL_MULTI;
            flush_v = FLUSH_WB;
            st_d    = ST_MEMW;
          end else if (bus.div_start && !bus.div_done) begin
            stall_v = STALL_MULTI;
            flush_v = FLUSH_WB;
            st_d    = ST_DIV;
          end else if (bus.br_taken) begin
            req       = 1'b1;
            req_tgt   = bus.br_target;
            req_flush = FLUSH_BR;
          end else if (bus.ld_use_stall) begin
            stall_v = STALL_LDUSE;
            flush_v = FLUSH_LDUSE;
          end
        end
        ST_DIV: begin
          if (bus.exc_req) begin
            req       = 1'b1;
            req_tgt   = bus.exc_vec;
            req_flush = FLUSH_ALL;
          end else if (bus.div_done) begin
            st_d = ST_RUN;
          end else begin
            stall_v = STALL_MULTI;
            flush_v = FLUSH_WB;
          end
        end
        ST_MEMW: begin
          if (bus.exc_req) begin
            pend_d = 1'b1;
            pvec_d = bus.exc_vec;
          end
          if (bus.dmem_ack) begin
            st_d = ST_RUN;
          end else begin
            stall_v = STALL_MULTI;
            flush_v = FLUSH_WB;
          end
        end
        ST_REDIR: begin
          rv      = 1'b1;
          rpc     = buf_q;
          flush_v = FLUSH_REDIR;
          // A new exception replaces the waiting target; only one target is presented.
          if (bus.exc_req) begin
            flush_v   = FLUSH_ALL;
            rpc       = bus.exc_vec;
            buf_d     = bus.exc_vec;
            redir_evt = 1'b1;
          end
          if (bus.if_ready) st_d = ST_RUN;
        end
        default: st_d = ST_RUN;
      endcase
      if (req) begin
        flush_v   = req_flush;
        redir_evt = 1'b1;
        if (bus.if_ready) begin
          rv   = 1'b1;
          rpc  = req_tgt;
          st_d = ST_RUN;
        end else begin
          buf_d = req_tgt;
          st_d  = ST_REDIR;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_RUN;
      buf_q  <= '0;
      pend_q <= 1'b0;
      pvec_q <= '0;
    end else begin
      st_q   <= st_d;
      buf_q  <= buf_d;
      pend_q <= pend_d;
      pvec_q <= pvec_d;
    end
  end

  assign bus.stall          = stall_v;
  assign bus.flush          = flush_v;
  assign bus.redirect_valid = rv;
  assign bus.redirect_pc    = rpc;
  assign state              = st_q;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_v != STALL_NONE),
    .cnt (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (redir_evt),
    .cnt (flush_cnt)
  );

endmodule
